// File: rtl/obi_sbr_sram_if.sv
// OBI request/response bundle between one manager and one SRAM subordinate.
interface obi_sbr_sram_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/obi_sbr_sram.sv
// OBI subordinate over a word-addressed SRAM: one outstanding transaction,
// GNT_WAIT idle cycles before grant, one-cycle response, saturating error count.
module obi_sbr_sram #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned GNT_WAIT = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    obi_sbr_sram_if.slave        bus,
    output logic [7:0]           err_cnt_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((GNT_WAIT > 0) ? (GNT_WAIT - 1) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   mem [DEPTH];

    logic          grant;
    logic          in_range;
    logic [AW-1:0] idx;

    assign idx      = bus.addr[AW-1:0];
    assign in_range = (bus.addr[31:AW] == '0);

    // Grant is combinational; reset masks it so a request during reset is never taken.
    assign grant   = !rst_i && bus.req &&
                     (((state == IDLE) && (GNT_WAIT == 0)) ||
                      ((state == WAIT) && (wait_cnt == '0)));
    assign bus.gnt = grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.err    <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            bus.rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        if (grant) begin
                            state <= RESP;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A dropped request is abandoned silently.
                    if (!bus.req) begin
                        state <= IDLE;
                    end else if (grant) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (bus.err && (err_cnt_o != 8'hFF)) begin
                        err_cnt_o <= err_cnt_o + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Response payload is captured at the grant edge, reads see the pre-write word.
            if (grant) begin
                bus.rvalid <= 1'b1;
                bus.err    <= !in_range;
                bus.rdata  <= (in_range && !bus.we) ? mem[idx] : '0;
            end
        end
    end

    // Array has no reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (grant && bus.we && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_obi_sbr_sram.sv
// Scoreboard bench for obi_sbr_sram: one instance without grant delay, one with GNT_WAIT=2.
module tb_obi_sbr_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req2 = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  cnt0;
    logic [7:0]  cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [16];
    int          model_errs = 0;

    always #5 clk = ~clk;

    obi_sbr_sram_if b0 ();
    obi_sbr_sram_if b2 ();

    assign b0.req = req0;  assign b0.addr = addr;  assign b0.we = we;
    assign b0.be  = be;    assign b0.wdata = wdata;
    assign b2.req = req2;  assign b2.addr = addr;  assign b2.we = we;
    assign b2.be  = be;    assign b2.wdata = wdata;

    obi_sbr_sram #(.DEPTH(16), .GNT_WAIT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(b0), .err_cnt_o(cnt0)
    );
    obi_sbr_sram #(.DEPTH(16), .GNT_WAIT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(b2), .err_cnt_o(cnt2)
    );

    // Reference behaviour of the DEPTH=16 instance; pushes the expected response.
    task automatic model_issue(input logic [31:0] a, input logic w, input logic [3:0] bev,
                               input logic [31:0] d);
        exp_t x;
        logic [3:0] i;
        i = a[3:0];
        if (a < 32'd16) begin
            x.err = 1'b0;
            if (w) begin
                x.rdata = '0;
                for (int k = 0; k < 4; k++)
                    if (bev[k]) model_mem[i][8*k +: 8] = d[8*k +: 8];
            end else begin
                x.rdata = model_mem[i];
            end
        end else begin
            x.err   = 1'b1;
            x.rdata = '0;
            if (model_errs < 255) model_errs++;
        end
        sb_q.push_back(x);
    endtask

    // One bounded transaction; returns grant latency (-1 if none) and the response.
    task automatic txn(input bit sel, input logic [31:0] a, input logic w, input logic [3:0] bev,
                       input logic [31:0] d, output int lat, output logic rv,
                       output logic [31:0] rd, output logic e);
        @(negedge clk);
        addr = a; we = w; be = bev; wdata = d;
        if (sel) req2 = 1'b1; else req0 = 1'b1;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if ((sel ? b2.gnt : b0.gnt) === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req0 = 1'b0; req2 = 1'b0;
        rv = sel ? b2.rvalid : b0.rvalid;
        rd = sel ? b2.rdata  : b0.rdata;
        e  = sel ? b2.err    : b0.err;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req2 = 1'b1; addr = 32'd3;
        @(negedge clk); @(negedge clk); #1;
        n_checks++;
        if (b0.gnt !== 1'b0 || b2.gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt: got %b/%b want 0/0", b0.gnt, b2.gnt);
        end
        n_checks++;
        if (b0.rvalid !== 1'b0 || b0.rdata !== 32'h0 || b0.err !== 1'b0) begin
            n_fail++; $display("FAIL reset_resp0: got rv=%b rd=%h err=%b want 0/0/0", b0.rvalid, b0.rdata, b0.err);
        end
        n_checks++;
        if (cnt0 !== 8'd0 || cnt2 !== 8'd0 || b2.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d rv2=%b want 0/0/0", cnt0, cnt2, b2.rvalid);
        end
        req0 = 1'b0; req2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int lat; logic rv; logic [31:0] rd; logic e; exp_t x;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] pat;
            pat = {16'h0, {4{4'(i)}}};
            model_issue(32'(i), 1'b1, 4'hF, pat);
            txn(1'b0, 32'(i), 1'b1, 4'hF, pat, lat, rv, rd, e);
            x = sb_q.pop_front();
            n_checks++;
            if (lat != 0 || rv !== 1'b1 || rd !== x.rdata || e !== x.err) begin
                n_fail++; $display("FAIL fill[%0d]: got lat=%0d rv=%b rd=%h err=%b want 0/1/%h/%b", i, lat, rv, rd, e, x.rdata, x.err);
            end
        end
    endtask

    task automatic test_read_hit();
        int lat; logic rv; logic [31:0] rd; logic e; exp_t x;
        model_issue(32'd3, 1'b0, 4'h0, 32'h0);
        txn(1'b0, 32'd3, 1'b0, 4'h0, 32'h0, lat, rv, rd, e);
        x = sb_q.pop_front();
        n_checks++;
        if (lat != 0 || rv !== 1'b1 || rd !== x.rdata || rd !== 32'h0000_3333 || e !== 1'b0) begin
            n_fail++; $display("FAIL read_hit: got lat=%0d rv=%b rd=%h err=%b want 0/1/00003333/0", lat, rv, rd, e);
        end
    endtask

    task automatic test_write_readback();
        int lat; logic rv; logic [31:0] rd; logic e; exp_t x;
        model_issue(32'd1, 1'b1, 4'hF, 32'h1337_C0DE);
        txn(1'b0, 32'd1, 1'b1, 4'hF, 32'h1337_C0DE, lat, rv, rd, e);
        x = sb_q.pop_front();
        n_checks++;
        if (rv !== 1'b1 || rd !== x.rdata || e !== x.err || dut0.mem[1] !== 32'h1337_C0DE) begin
            n_fail++; $display("FAIL full_write: got rv=%b rd=%h mem=%h want 1/0/1337c0de", rv, rd, dut0.mem[1]);
        end
        model_issue(32'd1, 1'b0, 4'h0, 32'h0);
        txn(1'b0, 32'd1, 1'b0, 4'hF, 32'hFFFF_FFFF, lat, rv, rd, e);
        x = sb_q.pop_front();
        n_checks++;
        if (rv !== 1'b1 || rd !== x.rdata || rd !== 32'h1337_C0DE || e !== 1'b0) begin
            n_fail++; $display("FAIL readback: got rv=%b rd=%h err=%b want 1/1337c0de/0", rv, rd, e);
        end
    endtask

    task automatic test_partial_write();
        int lat; logic rv; logic [31:0] rd; logic e; exp_t x;
        model_issue(32'd1, 1'b1, 4'b0011, 32'hAAAA_BBBB);
        txn(1'b0, 32'd1, 1'b1, 4'b0011, 32'hAAAA_BBBB, lat, rv, rd, e);
        x = sb_q.pop_front();
        n_checks++;
        if (rv !== 1'b1 || rd !== 32'h0 || rd !== x.rdata || e !== 1'b0) begin
            n_fail++; $display("FAIL partial_resp: got rv=%b rd=%h err=%b want 1/0/0", rv, rd, e);
        end
        n_checks++;
        if (dut0.mem[1] !== 32'h1337_BBBB || dut0.mem[1] !== model_mem[1]) begin
            n_fail++; $display("FAIL partial_mem: got %h want 1337bbbb", dut0.mem[1]);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic rv; logic [31:0] rd; logic e; exp_t x;
        logic [31:0] oor_addr [2];
        logic        oor_we [2];
        int          bad_words;
        oor_addr[0] = 32'd16;        oor_we[0] = 1'b0;
        oor_addr[1] = 32'h0000_0100; oor_we[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_issue(oor_addr[i], oor_we[i], 4'hF, 32'hFFFF_FFFF);
            txn(1'b0, oor_addr[i], oor_we[i], 4'hF, 32'hFFFF_FFFF, lat, rv, rd, e);
            x = sb_q.pop_front();
            n_checks++;
            if (rv !== 1'b1 || e !== 1'b1 || e !== x.err || rd !== x.rdata) begin
                n_fail++; $display("FAIL oor_resp[%0d]: got rv=%b rd=%h err=%b want 1/0/1", i, rv, rd, e);
            end
            @(negedge clk); @(negedge clk);
            n_checks++;
            if (cnt0 !== 8'(model_errs) || cnt0 !== 8'(i + 1)) begin
                n_fail++; $display("FAIL oor_cnt[%0d]: got %0d want %0d", i, cnt0, i + 1);
            end
        end
        bad_words = 0;
        for (int i = 0; i < 16; i++)
            if (dut0.mem[i] !== model_mem[i]) bad_words++;
        n_checks++;
        if (bad_words != 0) begin
            n_fail++; $display("FAIL oor_mem: got %0d changed words want 0", bad_words);
        end
    endtask

    task automatic test_grant_delay();
        int lat; logic rv; logic [31:0] rd; logic e; exp_t x;
        int stray;
        x.rdata = '0; x.err = 1'b0; sb_q.push_back(x);
        txn(1'b1, 32'd4, 1'b1, 4'hF, 32'h0000_0055, lat, rv, rd, e);
        x = sb_q.pop_front();
        n_checks++;
        if (lat != 2 || rv !== 1'b1 || rd !== x.rdata || e !== x.err) begin
            n_fail++; $display("FAIL delay_write: got lat=%0d rv=%b rd=%h err=%b want 2/1/0/0", lat, rv, rd, e);
        end
        x.rdata = 32'h0000_0055; x.err = 1'b0; sb_q.push_back(x);
        txn(1'b1, 32'd4, 1'b0, 4'h0, 32'h0, lat, rv, rd, e);
        x = sb_q.pop_front();
        n_checks++;
        if (lat != 2 || rv !== 1'b1 || rd !== x.rdata || e !== x.err) begin
            n_fail++; $display("FAIL delay_read: got lat=%0d rv=%b rd=%h err=%b want 2/1/55/0", lat, rv, rd, e);
        end
        // Request raised for one cycle only, then dropped while waiting.
        @(negedge clk);
        addr = 32'd4; we = 1'b0; req2 = 1'b1;
        stray = 0;
        #1 if (b2.gnt !== 1'b0) stray++;
        @(negedge clk);
        req2 = 1'b0;
        #1 if (b2.gnt !== 1'b0) stray++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (b2.rvalid !== 1'b0 || b2.gnt !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0 || cnt2 !== 8'd0) begin
            n_fail++; $display("FAIL abandon: got %0d stray gnt/rvalid cnt=%0d want 0/0", stray, cnt2);
        end
        txn(1'b1, 32'd4, 1'b0, 4'h0, 32'h0, lat, rv, rd, e);
        n_checks++;
        if (lat != 2 || rv !== 1'b1 || rd !== 32'h0000_0055) begin
            n_fail++; $display("FAIL after_abandon: got lat=%0d rv=%b rd=%h want 2/1/55", lat, rv, rd);
        end
    endtask

    task automatic test_back_to_back();
        int grants, resps, bad; exp_t x;
        grants = 0; resps = 0; bad = 0;
        @(negedge clk);
        addr = 32'd2; we = 1'b0; be = 4'h0; req0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (b0.rvalid === 1'b1) begin
                resps++;
                if (sb_q.size() == 0) bad++;
                else begin
                    x = sb_q.pop_front();
                    if (b0.rdata !== x.rdata || b0.err !== x.err) bad++;
                end
            end
            if (b0.gnt === 1'b1) begin
                grants++;
                model_issue(32'd2, 1'b0, 4'h0, 32'h0);
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        n_checks++;
        if (grants != 4 || resps != 4 || bad != 0 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL back_to_back: got gnt=%0d rv=%0d bad=%0d left=%0d want 4/4/0/0", grants, resps, bad, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic g, rv;
        @(negedge clk);
        addr = 32'd5; we = 1'b1; be = 4'hF; wdata = 32'hDEAD_BEEF; req0 = 1'b1;
        model_issue(32'd5, 1'b1, 4'hF, 32'hDEAD_BEEF);
        void'(sb_q.pop_back());
        #1 g = b0.gnt;
        @(negedge clk);
        rv = b0.rvalid;
        rst = 1'b1; req0 = 1'b0;
        n_checks++;
        if (g !== 1'b1 || rv !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got gnt=%b rv=%b want 1/1", g, rv);
        end
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b0 || cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset: got rv=%b cnt=%0d want 0/0", b0.rvalid, cnt0);
        end
        n_checks++;
        if (dut0.mem[5] !== 32'hDEAD_BEEF || dut0.mem[5] !== model_mem[5]) begin
            n_fail++; $display("FAIL mid_commit: got %h want deadbeef", dut0.mem[5]);
        end
        rst = 1'b0;
        model_errs = 0;
    endtask

    task automatic test_saturation();
        int resps, bad; int lat; logic rv; logic [31:0] rd; logic e;
        resps = 0; bad = 0;
        @(negedge clk);
        addr = 32'd16; we = 1'b0; req0 = 1'b1;
        for (int i = 0; i < 600; i++) begin
            #1;
            if (b0.gnt === 1'b1 && model_errs < 255) model_errs++;
            if (b0.rvalid === 1'b1) begin
                resps++;
                if (b0.err !== 1'b1 || b0.rdata !== 32'h0) bad++;
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        n_checks++;
        if (resps != 300 || bad != 0) begin
            n_fail++; $display("FAIL sat_stream: got rv=%0d bad=%0d want 300/0", resps, bad);
        end
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (cnt0 !== 8'd255 || cnt0 !== 8'(model_errs)) begin
            n_fail++; $display("FAIL sat_cnt: got %0d want 255", cnt0);
        end
        txn(1'b0, 32'h8000_0000, 1'b0, 4'h0, 32'h0, lat, rv, rd, e);
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (rv !== 1'b1 || e !== 1'b1 || rd !== 32'h0 || cnt0 !== 8'd255) begin
            n_fail++; $display("FAIL sat_hold: got rv=%b err=%b rd=%h cnt=%0d want 1/1/0/255", rv, e, rd, cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_hit();
        test_write_readback();
        test_partial_write();
        test_out_of_range();
        test_grant_delay();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 want earlier finish");
        $fatal(1);
    end
endmodule

// File: doc/obi_sbr_sram.md
# obi_sbr_sram

OBI subordinate that wraps a word-addressed on-chip SRAM array and answers one OBI transaction at a time with a configurable grant delay. It sits directly downstream of the OBI manager in `main`, one instance per memory region. It serves the `foo` and `bar` memories, and its error count feeds `err_cnt_o`. The array is named `mem` so benches can preload it hierarchically with `$readmemh`.

## Interface
- `DEPTH`, 16: number of 32-bit words in `mem`; power of two, 2..1024.
- `GNT_WAIT`, 0: idle cycles inserted between request and grant; 0..7.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset; synchronous and active-high.
- `req_i` input 1: OBI request valid.
- `gnt_o` output 1: OBI grant; combinational from state and `req_i`.
- `addr_i` input 32: word address; `mem[addr_i]`, no byte offset.
- `we_i` input 1: 1 = write, 0 = read.
- `be_i` input 4: byte enables; bit k covers `wdata_i[8k+7:8k]`.
- `wdata_i` input 32: write data.
- `rvalid_o` output 1: response valid, one-cycle pulse per granted transaction.
- `rdata_o` output 32: read data, valid while `rvalid_o`; 0 for writes and errors.
- `err_o` output 1: response error flag, valid while `rvalid_o`.
- `err_cnt_o` output 8: saturating count of error responses.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - `req_i`=1 and `GNT_WAIT`=0: `gnt_o`=1 this cycle, transaction captured at the edge, next state RESP.
  - `req_i`=1 and `GNT_WAIT`>0: load `wait_cnt` = `GNT_WAIT`-1, next state WAIT, `gnt_o`=0.
- WAIT:
  - `req_i`=0: abandon the request and return to IDLE. This is an OBI protocol violation and causes no error count.
  - `wait_cnt`≠0: decrement.
  - `wait_cnt`=0 and `req_i`=1: `gnt_o`=1, capture, next state RESP.
- RESP: `rvalid_o`=1 for exactly one cycle, then IDLE. `gnt_o`=0 in RESP, so at most one transaction is outstanding.
- Capture at the grant edge (`req_i` && `gnt_o`):
  - In range (`addr_i` < `DEPTH`), write: `mem[addr_i]` byte k is updated where `be_i[k]`=1. `rdata_o` is registered as 0 and `err_o` as 0.
  - In range, read: `rdata_o` is registered as `mem[addr_i]`, the pre-write value. `err_o`=0. `be_i` is ignored.
  - Out of range (any upper bit set), read or write: no memory change. `rdata_o`=0, `err_o`=1.
- `err_cnt_o` increments by 1 in the cycle `rvalid_o`=1 with `err_o`=1. It saturates at 255 and never wraps.
- `rdata_o` and `err_o` hold their last value outside RESP. Benches only sample them with `rvalid_o`.
- `mem` is not reset. Its contents survive `rst_i`.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `err_cnt_o`=0; state IDLE; `wait_cnt`=0.
- Grant latency: `req_i` rises in cycle n → `gnt_o`=1 in cycle n+`GNT_WAIT`.
- Response latency: exactly 1 cycle after grant. `rvalid_o`=1 in cycle n+`GNT_WAIT`+1.
- Write visibility: the array is updated at the grant edge. A read granted in a later transaction returns the new data.
- Throughput: one transaction per `GNT_WAIT`+2 cycles when `req_i` is held high.
- Held request: `req_i` held high through RESP starts a new transaction from IDLE in the cycle after RESP.
- `rst_i` mid-operation:
  - During WAIT or RESP: next cycle is IDLE with `rvalid_o`=0. The pending response is dropped.
  - A write already granted stays committed.
  - `rst_i` and `req_i` in the same cycle: reset wins and `gnt_o`=0.
- Simultaneous error and saturation: at `err_cnt_o`=255 the counter holds; `err_o` still asserts.

## Test plan
- Read hit (`DEPTH`=16, `GNT_WAIT`=0, `mem[3]`=0000_3333 preloaded): `req_i`=1, `addr_i`=3, `we_i`=0 → `gnt_o`=1 same cycle; next cycle `rvalid_o`=1, `rdata_o`=0000_3333, `err_o`=0.
- Full write then readback: write 1337_C0DE to `addr_i`=1 with `be_i`=F → `mem[1]`=1337_C0DE one cycle after grant; a read of addr 1 returns 1337_C0DE.
- Partial write: `mem[1]`=1337_C0DE, write AAAA_BBBB with `be_i`=0011 → `mem[1]`=1337_BBBB, `rdata_o`=0 on the write response.
- Out of range: read at `addr_i`=16, then write at `addr_i`=0000_0100 → both responses have `err_o`=1 and `rdata_o`=0. `err_cnt_o` goes 0→1→2 and all `mem` words are unchanged.
- Grant delay (`GNT_WAIT`=2): `req_i` rises in cycle 10 → `gnt_o` in cycle 12 and `rvalid_o` in cycle 13. With `req_i` dropped in cycle 11 → no grant, no response, state back to IDLE.
- Reset and saturation:
  - Assert `rst_i` in the RESP cycle → `rvalid_o`=0 the next cycle and `err_cnt_o`=0.
  - 300 back-to-back out-of-range reads → `err_cnt_o`=255 and stays there.
